// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU-op and mux-select encodings for the accumulator CPU
package cpu_pkg;

   // Instruction opcodes live in IR[7:4]; IR[3:0] is a register index or immediate.
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_NOR  = 4'h3;
   localparam logic [3:0] OP_LDR  = 4'h4;
   localparam logic [3:0] OP_STR  = 4'h5;
   localparam logic [3:0] OP_BZR  = 4'h6;
   localparam logic [3:0] OP_BZI  = 4'h7;
   localparam logic [3:0] OP_BNR  = 4'h8;
   localparam logic [3:0] OP_BNI  = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hB;
   localparam logic [3:0] OP_SHR  = 4'hC;
   localparam logic [3:0] OP_LDI  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   // ALU operation codes driven by the controller on aluOp.
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_NOR = 4'b0011;
   localparam logic [3:0] ALU_SHL = 4'b1011;
   localparam logic [3:0] ALU_SHR = 4'b1100;

   // Accumulator source select; 2'b01 is reserved and behaves as SEL_ALU.
   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_RSV = 2'b01;
   localparam logic [1:0] SEL_REG = 2'b10;
   localparam logic [1:0] SEL_IMM = 2'b11;

   // Program counter load source select.
   localparam logic SEL_PC_IMM = 1'b0;
   localparam logic SEL_PC_REG = 1'b1;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - 8-bit combinational ALU with zero/negative flags
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [3:0] alu_op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic       zero,
   output logic       neg
);

   // Operation select; a = register operand, b = accumulator. Unknown codes pass ACC through.
   always_comb begin
      result = b;
      case (alu_op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_NOR: result = ~(a | b);
         ALU_SHL: result = {b[6:0], 1'b0};
         ALU_SHR: result = {1'b0, b[7:1]};
         default: result = b;
      endcase
   end

   assign zero = (result == 8'h00);
   assign neg  = result[7];

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - PC, IR, ACC, register file and ALU of the accumulator CPU
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int RF_DEPTH = 16
)
(
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_data,
   input  logic            loadIR,
   input  logic            incPC,
   input  logic            loadPC,
   input  logic            selPC,
   input  logic            loadAcc,
   input  logic [1:0]      selACC,
   input  logic            loadReg,
   input  logic [3:0]      aluOp,
   input  logic            halt,
   output logic [7:0]      instr,
   output logic            flagZ,
   output logic            flagN,
   output logic [7:0]      acc_out,
   output logic [PC_W-1:0] pc_out
);

   localparam int RF_AW = $clog2(RF_DEPTH);

   logic [PC_W-1:0] pc;
   logic [7:0]      ir;
   logic [7:0]      acc;
   logic [7:0]      rf [RF_DEPTH];

   logic [RF_AW-1:0] rf_idx;
   logic [7:0]       reg_out;
   logic [7:0]       imm_ext;
   logic [7:0]       alu_result;
   logic [7:0]       acc_next;
   logic [PC_W-1:0]  pc_target;

   // Single combinational read port addressed by the operand field of IR.
   assign rf_idx  = ir[RF_AW-1:0];
   assign reg_out = rf[rf_idx];
   assign imm_ext = {4'b0000, ir[3:0]};

   cpu_alu u_alu (
      .alu_op (aluOp),
      .a      (reg_out),
      .b      (acc),
      .result (alu_result),
      .zero   (flagZ),
      .neg    (flagN)
   );

   // Accumulator source mux; the reserved select code falls through to the ALU.
   always_comb begin
      acc_next = alu_result;
      case (selACC)
         SEL_REG: acc_next = reg_out;
         SEL_IMM: acc_next = imm_ext;
         default: acc_next = alu_result;
      endcase
   end

   // Branch target: a register value or the zero-extended immediate.
   always_comb begin
      pc_target = PC_W'(ir[3:0]);
      if (selPC == SEL_PC_REG)
         pc_target = PC_W'(reg_out);
   end

   // PC: halt freezes, an explicit load beats increment, increment wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= '0;
      else if (!halt) begin
         if (loadPC)
            pc <= pc_target;
         else if (incPC)
            pc <= pc + PC_W'(1);
      end
   end

   // IR captures the fetched byte; reset leaves a NOP in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ir <= 8'h00;
      else if (loadIR && !halt)
         ir <= imem_data;
   end

   // ACC load from the selected source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= 8'h00;
      else if (loadAcc && !halt)
         acc <= acc_next;
   end

   // Register file write of the pre-edge ACC, which gives swap semantics with a same-cycle ACC load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++)
            rf[i] <= 8'h00;
      end else if (loadReg && !halt) begin
         rf[rf_idx] <= acc;
      end
   end

   assign imem_addr = pc;
   assign pc_out    = pc;
   assign instr     = ir;
   assign acc_out   = acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath against a behavioural model
module tb_cpu_datapath;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] imem_addr;
   logic [7:0] imem_data = 8'h00;
   logic       loadIR = 0, incPC = 0, loadPC = 0, selPC = 0, loadAcc = 0, loadReg = 0, halt = 0;
   logic [1:0] selACC = 2'b00;
   logic [3:0] aluOp = 4'b0000;
   logic [7:0] instr, acc_out, pc_out;
   logic       flagZ, flagN;

   int n_pass = 0;
   int n_total = 0;
   bit cmp_en = 0;

   // Behavioural model of the architectural state.
   int m_pc, m_ir, m_acc;
   int m_rf [16];
   int u_idx, u_reg, u_res, u_pc, u_acc;
   int c_idx, c_res;

   cpu_datapath #(.PC_W(8), .RF_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC), .selPC(selPC),
      .loadAcc(loadAcc), .selACC(selACC), .loadReg(loadReg), .aluOp(aluOp),
      .halt(halt), .instr(instr), .flagZ(flagZ), .flagN(flagN),
      .acc_out(acc_out), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   function automatic int alu_model(input logic [3:0] op, input int r, input int a);
      case (op)
         4'd1:    return (r + a) % 256;
         4'd2:    return (r - a + 256) % 256;
         4'd3:    return 255 - (r | a);
         4'd11:   return (a * 2) % 256;
         4'd12:   return a / 2;
         default: return a;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model state update on each rising edge, reset asynchronously.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 0; m_ir = 0; m_acc = 0;
         for (int i = 0; i < 16; i++) m_rf[i] = 0;
      end else if (!halt) begin
         u_idx = m_ir % 16;
         u_reg = m_rf[u_idx];
         u_res = alu_model(aluOp, u_reg, m_acc);
         u_pc  = m_pc;
         if (loadPC) u_pc = selPC ? u_reg : u_idx;
         else if (incPC) u_pc = (m_pc + 1) % 256;
         u_acc = m_acc;
         if (loadAcc) u_acc = (selACC == 2'b10) ? u_reg : (selACC == 2'b11) ? u_idx : u_res;
         if (loadReg) m_rf[u_idx] = m_acc;
         if (loadIR) m_ir = imem_data;
         m_pc  = u_pc;
         m_acc = u_acc;
      end
   end

   // Every-cycle comparison away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         c_idx = m_ir % 16;
         c_res = alu_model(aluOp, m_rf[c_idx], m_acc);
         chk("pc_out", pc_out, m_pc);
         chk("imem_addr", imem_addr, m_pc);
         chk("instr", instr, m_ir);
         chk("acc_out", acc_out, m_acc);
         chk("flagZ", flagZ, c_res == 0);
         chk("flagN", flagN, c_res / 128);
      end
   end

   task automatic idle();
      imem_data = 8'h00; loadIR = 0; incPC = 0; loadPC = 0; selPC = 0;
      loadAcc = 0; selACC = 2'b00; loadReg = 0; aluOp = 4'b0000; halt = 0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic load_ir(input logic [7:0] v);
      imem_data = v; loadIR = 1; cyc();
   endtask

   task automatic acc_imm();
      selACC = 2'b11; loadAcc = 1; cyc();
   endtask

   task automatic acc_reg();
      selACC = 2'b10; loadAcc = 1; cyc();
   endtask

   task automatic alu_acc(input logic [3:0] op);
      aluOp = op; selACC = 2'b00; loadAcc = 1; cyc();
   endtask

   task automatic store();
      loadReg = 1; cyc();
   endtask

   // Build an arbitrary ACC value from two immediates using RF[15] as scratch.
   task automatic set_acc(input logic [7:0] v);
      load_ir({4'hD, v[3:0]}); acc_imm();
      load_ir(8'h5F); store();
      load_ir({4'hD, v[7:4]}); acc_imm();
      repeat (4) alu_acc(4'b1011);
      load_ir(8'h0F); alu_acc(4'b0001);
   endtask

   task automatic set_reg(input logic [3:0] r, input logic [7:0] v);
      set_acc(v);
      load_ir({4'h5, r}); store();
   endtask

   initial begin
      idle();
      #3;
      chk("reset pc", pc_out, 0);
      chk("reset instr", instr, 0);
      chk("reset acc", acc_out, 0);
      chk("reset flagZ", flagZ, 1);
      chk("reset flagN", flagN, 0);
      @(posedge clk); #1;
      rst = 0;
      cmp_en = 1;

      // Mid-run asynchronous reset.
      set_reg(4'd4, 8'h23);
      set_acc(8'h5A);
      load_ir(8'h64);
      loadPC = 1; selPC = 1; cyc();
      chk("pre-reset pc", pc_out, 8'h23);
      chk("pre-reset acc", acc_out, 8'h5A);
      rst = 1; #1;
      chk("async pc", pc_out, 0);
      chk("async imem_addr", imem_addr, 0);
      chk("async acc", acc_out, 0);
      chk("async instr", instr, 0);
      chk("async flagZ", flagZ, 1);
      @(posedge clk); #1;
      rst = 0;

      // Fetch and load-immediate.
      imem_data = 8'hD7; loadIR = 1; incPC = 1; cyc();
      chk("fetch instr", instr, 8'hD7);
      chk("fetch pc", pc_out, 1);
      acc_imm();
      chk("ldi acc", acc_out, 8'h07);

      // ALU operations.
      set_reg(4'd3, 8'h05);
      set_acc(8'h07);
      load_ir(8'h03);
      aluOp = 4'b0010; #1;
      chk("sub flagN", flagN, 1);
      chk("sub flagZ", flagZ, 0);
      loadAcc = 1; selACC = 2'b00; cyc();
      chk("sub acc", acc_out, 8'hFE);
      alu_acc(4'b1100);
      chk("shr acc", acc_out, 8'h7F);
      set_reg(4'd3, 8'h81);
      set_acc(8'h7F);
      load_ir(8'h03);
      aluOp = 4'b0001; #1;
      chk("add flagZ", flagZ, 1);
      loadAcc = 1; cyc();
      chk("add acc", acc_out, 8'h00);
      aluOp = 4'b0101; #1;
      chk("undef op passes acc", flagZ, 1);
      cyc();

      // Store and register swap.
      set_acc(8'h3C);
      load_ir(8'h52); store();
      load_ir(8'h42); acc_reg();
      chk("str/ldr rf2", acc_out, 8'h3C);
      set_reg(4'd2, 8'h11);
      set_acc(8'h99);
      load_ir(8'h42);
      loadAcc = 1; selACC = 2'b10; loadReg = 1; cyc();
      chk("swap acc", acc_out, 8'h11);
      acc_reg();
      chk("swap rf2", acc_out, 8'h99);

      // Branches.
      load_ir(8'h79);
      loadPC = 1; selPC = 0; cyc();
      chk("bzi pc", pc_out, 8'h09);
      set_reg(4'd4, 8'hC8);
      load_ir(8'h64);
      loadPC = 1; selPC = 1; cyc();
      chk("bzr pc", pc_out, 8'hC8);
      load_ir(8'h79);
      loadPC = 1; incPC = 1; selPC = 0; cyc();
      chk("load beats inc", pc_out, 8'h09);

      // PC wrap, then halt with every load asserted.
      set_reg(4'd4, 8'hFF);
      set_acc(8'h11);
      load_ir(8'h64);
      loadPC = 1; selPC = 1; cyc();
      chk("pc at ff", pc_out, 8'hFF);
      incPC = 1; cyc();
      chk("pc wrap", pc_out, 8'h00);
      for (int k = 0; k < 5; k++) begin
         halt = 1; loadIR = 1; imem_data = 8'hAA; incPC = 1; loadPC = 1; selPC = 1;
         loadAcc = 1; selACC = 2'b10; loadReg = 1; aluOp = 4'b0001;
         @(posedge clk); #1;
      end
      idle();
      chk("halt pc", pc_out, 8'h00);
      chk("halt instr", instr, 8'h64);
      chk("halt acc", acc_out, 8'h11);
      acc_reg();
      chk("halt rf4", acc_out, 8'hFF);

      @(posedge clk); #1;
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Execution datapath for the 8-bit accumulator microprocessor. It sits at the receiving end of the controller's control-signal interface. Each cycle it applies loadIR/incPC/loadPC/loadAcc/loadReg/selPC/selACC/aluOp/halt to its PC, IR, ACC, 16-entry register file and ALU. It returns instr, flagZ and flagN to the controller. Instruction memory is external and is read combinationally at imem_addr = PC.

Parameters:
PC_W, 8, program counter width; imem_addr width.
RF_DEPTH, 16, register file entries (index = IR[3:0]).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
imem_addr  out  PC_W  instruction memory address (= PC)
imem_data  in  8  instruction memory read data (combinational)
loadIR  in  1  IR <= imem_data
incPC  in  1  PC <= PC+1
loadPC  in  1  PC <= selected source
selPC  in  1  1 = RF[IR[3:0]], 0 = zero-extended IR[3:0]
loadAcc  in  1  ACC <= selected source
selACC  in  2  00 ALU, 10 RF[IR[3:0]], 11 zero-extended IR[3:0], 01 reserved
loadReg  in  1  RF[IR[3:0]] <= ACC
aluOp  in  4  0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR
halt  in  1  freeze all architectural state
instr  out  8  IR contents
flagZ  out  1  ALU result == 0 (combinational)
flagN  out  1  ALU result[7] (combinational)
acc_out  out  8  ACC contents (debug/observe)
pc_out  out  PC_W  PC contents (debug/observe)

Behaviour:
- Reset (async, rst=1):
  - PC=0, IR=8'h00 (NOP), ACC=0, all RF entries=0.
  - Outputs follow immediately: imem_addr=0, instr=0, acc_out=0, pc_out=0, flagZ=1 (ALU result of 0), flagN=0.
  - Deasserting reset mid-program restarts execution at PC=0.
- Register read: regOut = RF[IR[3:0]], combinational, single read port.
- ALU (combinational, 8-bit, carry/borrow discarded, wrap mod 256):
  - ADD: regOut + ACC.
  - SUB: regOut - ACC.
  - NOR: ~(regOut | ACC).
  - SHL: {ACC[6:0],0}.
  - SHR: {0,ACC[7:1]} (logical).
  - Any other aluOp value, including X: result = ACC.
- flagZ and flagN are derived from the current ALU result every cycle. The controller is responsible for sampling them only on ALU instructions.
- PC update priority per edge:
  1. halt=1: hold.
  2. loadPC=1: PC <= selPC ? regOut[PC_W-1:0] : {0, IR[3:0]}.
  3. incPC=1: PC <= PC+1, wrapping from all-ones to 0.
  4. Otherwise: hold.
  - loadPC and incPC together: loadPC wins.
- IR: loadIR=1 and halt=0 -> IR <= imem_data. Otherwise hold.
- ACC: loadAcc=1 and halt=0 -> ACC <= mux(selACC). selACC=01 loads the ALU result (treated as 00).
- RF write: loadReg=1 and halt=0 -> RF[IR[3:0]] <= ACC on the edge.
  - Read-during-write on the same index returns the old value in that cycle.
  - loadAcc and loadReg together: RF captures the old ACC and ACC takes its new value (register swap semantics).
- Latency:
  - All loads are visible one cycle after the edge.
  - flagZ/flagN are valid in the same cycle as the operands.
  - A branch target is visible on imem_addr the cycle after the EXEC edge.
- halt=1 blocks every write. Combinational outputs keep tracking the frozen state.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (NOP, ADD, SUB, NOR, LDR, STR, BZR, BZI, BNR, BNI, SHL, SHR, LDI, HALT).
  - aluOp encodings.
  - selACC encodings (SEL_ALU=00, SEL_REG=10, SEL_IMM=11).
  - selPC encodings.
- The controller and this block both import cpu_pkg.
- One sub-module is natural: cpu_alu (aluOp, a=regOut, b=ACC -> result, zero, neg).
- The register file stays inline.

Test Plan:
- Reset mid-run: hold rst=1 with PC=0x23 and ACC=0x5A -> PC, ACC and IR read 0 immediately, before any clock edge; flagZ=1.
- Fetch: imem_data=0xD7, loadIR=1, incPC=1 -> IR=0xD7, PC=1. Then selACC=11, loadAcc=1 -> ACC=0x07.
- ALU: RF[3]=0x05, ACC=0x07, aluOp=SUB -> flagN=1, ALU result=0xFE. With loadAcc -> ACC=0xFE. Next SHR -> 0x7F. ADD with RF[3]=0x81, ACC=0x7F -> result 0x00, flagZ=1.
- Store/load swap: ACC=0x3C, IR=0x52, loadReg=1 -> RF[2]=0x3C. IR=0x42 with loadAcc, selACC=10, and RF[2] preloaded to 0x11 while loadReg=1 in the same cycle -> RF[2]=old ACC and ACC=0x11.
- Branch: IR=0x79 with loadPC=1, selPC=0 -> PC=0x09. IR=0x64, RF[4]=0xC8, selPC=1 -> PC=0xC8. loadPC and incPC both set -> PC=target, not PC+1.
- Halt/wrap: PC=0xFF with incPC -> PC=0x00. With halt=1 and every load asserted for 5 cycles -> PC, IR, ACC and RF unchanged.
